// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the halt encoding, fetch states and
// the opcode field position, so fetch and decode agree on one source.
package cpu_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 10;
  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 6;

  localparam logic [DATA_W-1:0] HALT_WORD = 10'b0010000010;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    HALT_PEND = 2'd2,
    HALTED    = 2'd3
  } fetch_state_e;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [DATA_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: reset value, absolute load and wrapping increment.
// A load takes priority over an increment in the same cycle.
module pc_reg import cpu_pkg::*; #(
  parameter int            AW       = 10,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_val,
  input  logic          inc_en,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  // next PC selection
  always_comb begin
    pc_d = pc_q;
    if (set_en) begin
      pc_d = set_val;
    end else if (inc_en) begin
      pc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the ROM from the PC, registers one word into a
// valid/ready output slot, follows redirects and stops after emitting the halt word.
module fetch_unit import cpu_pkg::*; #(
  parameter int                  ADDR_W    = cpu_pkg::ADDR_W,
  parameter int                  DATA_W    = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]   RESET_PC  = {ADDR_W{1'b0}},
  parameter logic [DATA_W-1:0]   HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  fetch_state_e      state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              halted_q, halted_d;
  logic [15:0]       fetch_count_q, fetch_count_d;

  logic              transfer_s;
  logic              slot_free_s;
  logic              pc_set_s;
  logic              pc_inc_s;
  logic [ADDR_W-1:0] pc_set_val_s;
  logic [ADDR_W-1:0] pc_s;

  pc_reg #(
    .AW       (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .set_en  (pc_set_s),
    .set_val (pc_set_val_s),
    .inc_en  (pc_inc_s),
    .pc      (pc_s)
  );

  // a redirect in the same cycle cancels the handoff to decode
  assign transfer_s  = out_valid_q && out_ready && !redirect_valid;
  assign slot_free_s = !out_valid_q || transfer_s;

  // fetch control, output slot and counter next-state
  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    pc_set_s      = 1'b0;
    pc_inc_s      = 1'b0;
    pc_set_val_s  = redirect_target;

    case (state_q)
      IDLE: begin
        if (start) begin
          pc_set_s     = 1'b1;
          pc_set_val_s = RESET_PC;
          state_d      = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_set_s    = 1'b1;
          out_valid_d = 1'b0;
        end else if (slot_free_s) begin
          out_instr_d = rom_data;
          out_pc_d    = pc_s;
          out_valid_d = 1'b1;
          pc_inc_s    = 1'b1;
          if (rom_data == HALT_WORD) begin
            state_d = HALT_PEND;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = FETCH;
        end
      end
      HALT_PEND: begin
        if (redirect_valid) begin
          pc_set_s    = 1'b1;
          out_valid_d = 1'b0;
          state_d     = FETCH;
        end else if (transfer_s) begin
          out_valid_d = 1'b0;
          state_d     = HALTED;
        end else begin
          state_d = HALT_PEND;
        end
      end
      HALTED: begin
        out_valid_d = 1'b0;
        state_d     = HALTED;
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    halted_d = (state_d == HALTED);

    if (transfer_s && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
  end

  // control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_instr_q   <= {DATA_W{1'b0}};
      out_pc_q      <= {ADDR_W{1'b0}};
      halted_q      <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_addr    = pc_s;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the fetch rules.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  rom_addr;
  logic [9:0]  rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_instr;
  logic [9:0]  out_pc;
  logic        redirect_valid;
  logic [9:0]  redirect_target;
  logic        halted;
  logic [15:0] fetch_count;

  logic [9:0] rom [0:1023];

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 fetching, 2 halt word pending, 3 halted
  int m_mode, m_pc, m_valid, m_instr, m_opc, m_count;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0; m_count = 0;
  endtask

  // advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit         xfer;
    logic [9:0] word;
    xfer = (m_valid != 0) && out_ready && !redirect_valid;
    word = rom[m_pc];
    if (xfer && m_count < 65535) m_count++;
    case (m_mode)
      0: if (start) begin m_pc = 0; m_mode = 1; end
      1: begin
        if (redirect_valid) begin
          m_pc = int'(redirect_target); m_valid = 0;
        end else if (m_valid == 0 || xfer) begin
          m_instr = int'(word); m_opc = m_pc; m_valid = 1;
          m_pc = (m_pc + 1) % 1024;
          if (word == HALT_WORD) m_mode = 2;
        end
      end
      2: begin
        if (redirect_valid) begin
          m_valid = 0; m_pc = int'(redirect_target); m_mode = 1;
        end else if (xfer) begin
          m_valid = 0; m_mode = 3;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("rom_addr", 32'(rom_addr), m_pc);
    check("out_valid", 32'(out_valid), m_valid);
    check("out_instr", 32'(out_instr), m_instr);
    check("out_pc", 32'(out_pc), m_opc);
    check("halted", 32'(halted), (m_mode == 3) ? 1 : 0);
    check("fetch_count", 32'(fetch_count), m_count);
  endtask

  task automatic cycle(input bit st, input bit rdy, input bit rv, input int tgt);
    logic [31:0] t;
    t = tgt;
    start = st; out_ready = rdy; redirect_valid = rv; redirect_target = t[9:0];
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // reset asserted and released between clock edges
  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    compare_all();
  endtask

  task automatic fill_rom(input int halt_pct);
    for (int a = 0; a < 1024; a++) begin
      logic [9:0] w;
      w = 10'($urandom_range(0, 1023));
      while (w == HALT_WORD) w = 10'($urandom_range(0, 1023));
      if (int'($urandom_range(0, 99)) < halt_pct) w = HALT_WORD;
      rom[a] = w;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 10'd0;
    fill_rom(0);
    rom[0] = 10'h310; rom[1] = 10'h319; rom[2] = 10'h374; rom[3] = 10'h155;
    rom[4] = 10'h348; rom[5] = 10'h3E8; rom[11] = 10'h082;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    compare_all();
    check("reset_valid", 32'(out_valid), 32'd0);

    // start, then streaming at one word per cycle
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("start_no_load", 32'(out_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("first_pc", 32'(out_pc), 32'd0);
    check("first_instr", 32'(out_instr), 32'h310);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("second_instr", 32'(out_instr), 32'h319);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("third_instr", 32'(out_instr), 32'h374);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("count_after_3", 32'(fetch_count), 32'd3);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("pc4_instr", 32'(out_instr), 32'h348);

    // stall for three cycles
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 0);
      check("stall_pc", 32'(out_pc), 32'd4);
      check("stall_instr", 32'(out_instr), 32'h348);
      check("stall_rom_addr", 32'(rom_addr), 32'd5);
    end
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("release_pc", 32'(out_pc), 32'd5);
    check("release_instr", 32'(out_instr), 32'h3E8);

    // redirect onto the halt word
    cycle(1'b0, 1'b1, 1'b1, 11);
    check("redirect_bubble", 32'(out_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("halt_word_pc", 32'(out_pc), 32'd11);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("halted_set", 32'(halted), 32'd1);
    check("halted_invalid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 3);
    check("halted_sticky", 32'(halted), 32'd1);

    // held halt word squashed by an older redirect
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b1, 11);
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b1, 3);
    check("squash_halted", 32'(halted), 32'd0);
    check("squash_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("after_squash_pc", 32'(out_pc), 32'd3);
    check("after_squash_instr", 32'(out_instr), 32'h155);

    // PC wrap
    cycle(1'b0, 1'b1, 1'b1, 1023);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("wrap_pc_1023", 32'(out_pc), 32'd1023);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("wrap_pc_0", 32'(out_pc), 32'd0);

    // asynchronous reset in the middle of a stall
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2;
    reset = 1'b0;
    cycle(1'b0, 1'b1, 1'b1, 5);
    check("idle_ignores_redirect", 32'(rom_addr), 32'd0);
    check("idle_no_valid", 32'(out_valid), 32'd0);

    // randomized traffic with occasional halts and resets
    fill_rom(3);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0 || (m_mode == 3 && $urandom_range(0, 19) == 0)) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 11) == 0), int'($urandom_range(0, 1023)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
